// File: rtl/tinisoc_pkg.sv
// Shared TiniSOC constants and the fetch-entry record used by the fetch stage.
package tinisoc_pkg;

  // First PC fetched after reset.
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // srli r0,r0,0 : harmless filler presented whenever no real word is ready.
  localparam logic [31:0] NOP_WORD = 32'h4000_0009;

  // Prefetch queue entries; also the cap on buffered plus outstanding fetches.
  localparam int unsigned FETCH_DEPTH = 2;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/ready plus rvalid bus between the fetch stage and memory.
interface ifetch_unit_if;

  logic [31:0] oIM_addr;
  logic        oIM_req;
  logic        iIM_ready;
  logic        iIM_rvalid;
  logic [31:0] iIM_rdata;

  // The fetch stage drives address/request and consumes ready/response.
  modport master (
    output oIM_addr,
    output oIM_req,
    input  iIM_ready,
    input  iIM_rvalid,
    input  iIM_rdata
  );

  // The memory side sees the mirror image.
  modport slave (
    input  oIM_addr,
    input  oIM_req,
    output iIM_ready,
    output iIM_rvalid,
    output iIM_rdata
  );

endinterface

// File: rtl/ifetch_unit_fifo.sv
// Small synchronous FIFO with flush; a pop and a push in the same cycle are
// legal even when full because the pop frees the head slot first.
module ifetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             pushData_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             popData_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPop;
  logic             doPush;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign doPop     = pop_i && (count_q != '0);
  assign doPush    = push_i && ((count_q != CW'(DEPTH)) || doPop);
  assign popData_o = mem_q[rdPtr_q];
  assign count_o   = count_q;

  // Next pointer and occupancy values; flush empties the queue outright.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPop) begin
        rdPtr_d = nextPtr(rdPtr_q);
      end
      if (doPush) begin
        wrPtr_d = nextPtr(wrPtr_q);
      end
      count_d = count_q + CW'(doPush) - CW'(doPop);
    end
  end

  // Occupancy state, cleared by the synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the count decides which slots are meaningful.
  always_ff @(posedge clock) begin
    if (doPush && !flush_i) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// TiniSOC instruction-fetch stage: owns the PC, issues in-order fetches, buffers
// returned words, and hands one instruction per cycle to the pipeline register wall.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = tinisoc_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD = tinisoc_pkg::NOP_WORD,
  parameter int unsigned DEPTH    = tinisoc_pkg::FETCH_DEPTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iStall,
  input  logic          iRedirect,
  input  logic [31:0]   iRedirect_pc,
  ifetch_unit_if.master im,
  output logic [31:0]   oInstruction,
  output logic [31:0]   oInstruction_pc,
  output logic          oInstruction_valid
);

  localparam int unsigned   CW         = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DepthLimit = (CW + 1)'(DEPTH);

  typedef tinisoc_pkg::fetch_entry_t entry_t;

  // Architectural fetch state.
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  // Output registers facing decode.
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   instrPc_q, instrPc_d;
  logic          valid_q, valid_d;

  // Queue plumbing.
  logic [CW-1:0] queueCount;
  logic [CW-1:0] tagCount;
  entry_t        queueHead;
  entry_t        queuePush;
  logic [31:0]   tagHead;
  logic [CW:0]   inFlight;
  logic          reqValid;
  logic          reqAccept;
  logic          rspDrop;
  logic          queuePushEn;
  logic          queuePopEn;

  // A new request is only allowed while buffered plus outstanding words leave room,
  // which guarantees every response has a queue slot waiting for it.
  assign inFlight    = {1'b0, queueCount} + {1'b0, outstanding_q};
  assign reqValid    = reset && !iRedirect && (inFlight < DepthLimit);
  assign reqAccept   = reqValid && im.iIM_ready;

  // Responses belonging to a fetch stream abandoned by a redirect are thrown away,
  // including one that lands in the redirect cycle itself.
  assign rspDrop     = iRedirect || (discard_q != '0);
  assign queuePushEn = im.iIM_rvalid && !rspDrop;
  assign queuePopEn  = !iRedirect && !iStall && (queueCount != '0);
  assign queuePush   = '{pc: tagHead, instr: im.iIM_rdata};

  assign im.oIM_addr = pc_q;
  assign im.oIM_req  = reqValid;

  assign oInstruction       = instr_q;
  assign oInstruction_pc    = instrPc_q;
  assign oInstruction_valid = valid_q;

  // Returned words with their PCs, waiting for decode to take them.
  ifetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) prefetchQueue (
    .clock      (clock),
    .reset      (reset),
    .flush_i    (iRedirect),
    .push_i     (queuePushEn),
    .pushData_i (queuePush),
    .pop_i      (queuePopEn),
    .popData_o  (queueHead),
    .count_o    (queueCount)
  );

  // PCs of accepted requests, in issue order; every response pops one, kept or
  // dropped, so this queue is never flushed by a redirect.
  ifetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) tagQueue (
    .clock      (clock),
    .reset      (reset),
    .flush_i    (1'b0),
    .push_i     (reqAccept),
    .pushData_i (pc_q),
    .pop_i      (im.iIM_rvalid),
    .popData_o  (tagHead),
    .count_o    (tagCount)
  );

  // PC, outstanding and discard bookkeeping; a redirect turns everything still in
  // flight (less any response arriving now) into words to be discarded.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (iRedirect) begin
      pc_d          = iRedirect_pc & ~32'd3;
      outstanding_d = outstanding_q - CW'(im.iIM_rvalid);
      discard_d     = outstanding_q - CW'(im.iIM_rvalid);
    end else begin
      if (reqAccept) begin
        pc_d = pc_q + 32'd4;
      end
      outstanding_d = outstanding_q + CW'(reqAccept) - CW'(im.iIM_rvalid);
      if (im.iIM_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
    end
  end

  // Output register selection: redirect squashes to NOP, stall holds, otherwise
  // the queue head is taken or a NOP bubble is shown with the old PC kept.
  always_comb begin
    instr_d   = instr_q;
    instrPc_d = instrPc_q;
    valid_d   = valid_q;
    if (iRedirect) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (!iStall) begin
      if (queueCount != '0) begin
        instr_d   = queueHead.instr;
        instrPc_d = queueHead.pc;
        valid_d   = 1'b1;
      end else begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
    end
  end

  // State update with synchronous active-low reset back to the boot PC.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      instr_q       <= NOP_WORD;
      instrPc_q     <= 32'h0000_0000;
      valid_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      instr_q       <= instr_d;
      instrPc_q     <= instrPc_d;
      valid_q       <= valid_d;
    end
  end

  // Memory must never answer a request that was not made.
  assert property (@(posedge clock) disable iff (!reset)
    im.iIM_rvalid |-> (outstanding_q != '0));

  // Buffered plus in-flight words never exceed the queue capacity.
  assert property (@(posedge clock) disable iff (!reset)
    inFlight <= DepthLimit);

  // Only fetches actually in flight can be marked for discard.
  assert property (@(posedge clock) disable iff (!reset)
    discard_q <= outstanding_q);

  // Every outstanding request owns exactly one PC tag.
  assert property (@(posedge clock) disable iff (!reset)
    tagCount == outstanding_q);

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit: the expected instruction stream is
// derived from the reset/redirect history alone and checked as decode sees it.
module tb_ifetch_unit;
  import tinisoc_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iStall = 1'b0;
  logic        iRedirect = 1'b0;
  logic [31:0] iRedirect_pc = 32'h0;
  logic [31:0] oInstruction;
  logic [31:0] oInstruction_pc;
  logic        oInstruction_valid;

  ifetch_unit_if im ();

  ifetch_unit dut (
    .clock              (clock),
    .reset              (reset),
    .iStall             (iStall),
    .iRedirect          (iRedirect),
    .iRedirect_pc       (iRedirect_pc),
    .im                 (im),
    .oInstruction       (oInstruction),
    .oInstruction_pc    (oInstruction_pc),
    .oInstruction_valid (oInstruction_valid)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;
  int validSeen = 0;

  // Expected stream: the sequential PCs decode should see after the last reset/redirect.
  fetch_entry_t expQ [$];
  fetch_entry_t expHead;
  logic [31:0]  streamNext = 32'h0;

  // Driver view of what the DUT sampled at the most recent edge.
  logic        resetAtEdge = 1'b0;
  logic        stallAtEdge = 1'b0;
  logic        redirectAtEdge = 1'b0;

  // What the output registers should currently hold.
  logic [31:0] lastPc = 32'h0;
  logic [31:0] lastInstr = NOP_WORD;
  logic        lastValid = 1'b0;

  // Memory model knobs.
  int memMode = 0;
  int memLat = 0;
  int memJitter = 0;

  typedef struct {
    logic [31:0] addr;
    int          readyAt;
  } pend_t;
  pend_t pend [$];
  int    memCyc = 0;

  // Memory image: a scrambled function of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic refill();
    while (expQ.size() < 16) begin
      expQ.push_back('{pc: streamNext, instr: memWord(streamNext)});
      streamNext = streamNext + 32'd4;
    end
  endtask

  task automatic startStream(input logic [31:0] pc);
    expQ.delete();
    streamNext = pc;
    refill();
  endtask

  // Drive one cycle of inputs, let the edge happen, then update the stream model.
  task automatic applyStimulus(input logic stall, input logic redirect, input logic [31:0] rpc, input logic rst);
    iStall = stall;
    iRedirect = redirect;
    iRedirect_pc = rpc;
    reset = rst;
    #2;
    if (!rst || redirect) checkOutput("req_blocked", {31'b0, im.oIM_req}, 32'd0);
    @(posedge clock);
    resetAtEdge = rst;
    stallAtEdge = stall;
    redirectAtEdge = redirect;
    if (!rst) startStream(RESET_PC);
    else if (redirect) startStream(rpc & ~32'd3);
    refill();
    #1;
  endtask

  // Monitor: sample outputs mid-cycle and score them against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (!resetAtEdge) begin
        checkOutput("rst_instr", oInstruction, NOP_WORD);
        checkOutput("rst_pc", oInstruction_pc, 32'h0);
        checkOutput("rst_valid", {31'b0, oInstruction_valid}, 32'd0);
        lastPc = 32'h0;
        lastInstr = NOP_WORD;
        lastValid = 1'b0;
      end else if (redirectAtEdge) begin
        checkOutput("redir_instr", oInstruction, NOP_WORD);
        checkOutput("redir_valid", {31'b0, oInstruction_valid}, 32'd0);
        checkOutput("redir_pc_hold", oInstruction_pc, lastPc);
        lastInstr = NOP_WORD;
        lastValid = 1'b0;
      end else if (stallAtEdge) begin
        checkOutput("stall_instr", oInstruction, lastInstr);
        checkOutput("stall_pc", oInstruction_pc, lastPc);
        checkOutput("stall_valid", {31'b0, oInstruction_valid}, {31'b0, lastValid});
      end else if (oInstruction_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("exp_underflow", 32'd0, 32'd1);
        end else begin
          expHead = expQ.pop_front();
          checkOutput("out_pc", oInstruction_pc, expHead.pc);
          checkOutput("out_instr", oInstruction, expHead.instr);
          lastPc = expHead.pc;
          lastInstr = expHead.instr;
          lastValid = 1'b1;
          validSeen++;
        end
      end else begin
        checkOutput("bubble_instr", oInstruction, NOP_WORD);
        checkOutput("bubble_pc", oInstruction_pc, lastPc);
        lastInstr = NOP_WORD;
        lastValid = 1'b0;
      end
    end
  end

  // Instruction memory: in-order responses, at least one cycle after acceptance.
  initial begin
    logic        sRst, sAcc, sRv;
    logic [31:0] sAddr;
    im.iIM_ready = 1'b1;
    im.iIM_rvalid = 1'b0;
    im.iIM_rdata = 32'h0;
    forever begin
      @(negedge clock);
      sRst = reset;
      sAcc = im.oIM_req && im.iIM_ready;
      sRv = im.iIM_rvalid;
      sAddr = im.oIM_addr;
      @(posedge clock);
      memCyc++;
      if (!sRst) begin
        pend.delete();
      end else begin
        if (sRv && pend.size() > 0) void'(pend.pop_front());
        if (sAcc) pend.push_back('{addr: sAddr,
          readyAt: memCyc + memLat + ((memJitter != 0) ? int'($urandom_range(0, 2)) : 0)});
      end
      #1;
      case (memMode)
        0: im.iIM_ready = 1'b1;
        1: im.iIM_ready = ($urandom_range(0, 3) != 0);
        default: im.iIM_ready = 1'b0;
      endcase
      if (pend.size() > 0 && pend[0].readyAt <= memCyc) begin
        im.iIM_rvalid = 1'b1;
        im.iIM_rdata = memWord(pend[0].addr);
      end else begin
        im.iIM_rvalid = 1'b0;
        im.iIM_rdata = $urandom;
      end
    end
  end

  // Directed scenarios followed by a long randomized run.
  initial begin
    logic        rStall, rRedir, rRst;
    logic [31:0] rPc;

    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("reset_addr", im.oIM_addr, RESET_PC);

    // Zero-wait streaming from reset.
    memMode = 0; memLat = 0; memJitter = 0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("first_valid", {31'b0, oInstruction_valid}, 32'd1);
    checkOutput("first_pc", oInstruction_pc, RESET_PC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("second_valid", {31'b0, oInstruction_valid}, 32'd1);
    checkOutput("second_pc", oInstruction_pc, RESET_PC + 32'd4);

    // Stall long enough for the queue to fill and requests to stop.
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("stall_req_low", {31'b0, im.oIM_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("resume1_valid", {31'b0, oInstruction_valid}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("resume2_valid", {31'b0, oInstruction_valid}, 32'd1);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect while slow responses are in flight.
    memLat = 2;
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    checkOutput("redir_addr", im.oIM_addr, 32'h0000_0100);
    memLat = 0;
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Misaligned redirect during a stall.
    applyStimulus(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    checkOutput("redir_stall_valid", {31'b0, oInstruction_valid}, 32'd0);
    checkOutput("redir_align_addr", im.oIM_addr, 32'h0000_0100);
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Memory not ready: queue drains, request stays up.
    memMode = 2;
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("notready_req", {31'b0, im.oIM_req}, 32'd1);
    checkOutput("notready_valid", {31'b0, oInstruction_valid}, 32'd0);
    memMode = 0;
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset with responses still in flight.
    memLat = 2;
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("midrst_addr", im.oIM_addr, RESET_PC);
    memLat = 0;
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic including wrap-around redirect targets.
    memMode = 1; memJitter = 1;
    for (int i = 0; i < 3000; i++) begin
      rStall = ($urandom_range(0, 3) == 0);
      rRedir = ($urandom_range(0, 19) == 0);
      rRst   = ($urandom_range(0, 99) != 0);
      rPc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                           : ($urandom & 32'h0000_0FFF);
      applyStimulus(rStall, rRedir, rPc, rRst);
    end

    checkOutput("progress", {31'b0, (validSeen >= 500)}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
